// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream loader that assembles 32-bit words into instruction memory
module instruction_loader #(
  parameter int NUM_WORDS  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                state, state_nxt;
  logic [1:0]            byte_idx;
  logic [31:0]           word_buf;
  logic [31:0]           buf_nxt;
  logic                  last_seen;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  accept;
  logic                  at_end;

  assign accept = (state == RECV) && byte_valid;
  assign at_end = last_seen || (addr_q == LAST_ADDR);

  // Next-state selection: a word closes on its 4th byte or on an early last byte
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RECV;
      RECV:    if (accept && ((byte_idx == 2'd3) || byte_last)) state_nxt = WRITE;
      WRITE:   state_nxt = at_end ? DONE : RECV;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Place the incoming byte at its MSB-first slot; the first byte clears the rest so short words zero-fill
  always_comb begin
    buf_nxt = word_buf;
    unique case (byte_idx)
      2'd0:    buf_nxt = {byte_data, 24'h000000};
      2'd1:    buf_nxt = {word_buf[31:24], byte_data, 16'h0000};
      2'd2:    buf_nxt = {word_buf[31:16], byte_data, 8'h00};
      default: buf_nxt = {word_buf[31:8], byte_data};
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath: byte index, word buffer, address and word counter
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx  <= 2'd0;
      word_buf  <= 32'h0;
      last_seen <= 1'b0;
      addr_q    <= '0;
      count_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            byte_idx  <= 2'd0;
            last_seen <= 1'b0;
            addr_q    <= '0;
            count_q   <= '0;
          end
        end
        RECV: begin
          if (accept) begin
            word_buf  <= buf_nxt;
            byte_idx  <= byte_idx + 2'd1;
            last_seen <= byte_last;
          end
        end
        WRITE: begin
          count_q <= count_q + CNT_ONE;
          if (!at_end) begin
            addr_q   <= addr_q + ADDR_ONE;
            byte_idx <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign byte_ready = (state == RECV);
  assign wr_en      = (state == WRITE);
  assign done       = (state == DONE);
  assign cpu_hold   = (state != IDLE);
  assign wr_address = addr_q;
  assign wr_data    = word_buf;
  assign word_count = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - scoreboard bench for instruction_loader with randomized byte streams
module tb_instruction_loader;

  localparam int NUM_WORDS  = 32;
  localparam int ADDR_WIDTH = 5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  byte_valid = 1'b0;
  logic [7:0]            byte_data = 8'h00;
  logic                  byte_last = 1'b0;
  logic                  byte_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [31:0]           wr_data;
  logic                  cpu_hold;
  logic                  done;
  logic [ADDR_WIDTH:0]   word_count;

  instruction_loader #(.NUM_WORDS(NUM_WORDS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_address(wr_address),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_acc = -10;
  int done_seen = 0;
  int wr_seen = 0;

  logic [36:0] exp_q[$];
  int          done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expected writes / done events whenever the DUT presents them
  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid && byte_ready) last_acc = cyc;
      if (wr_en) begin
        wr_seen++;
        check("wr_latency", 64'(cyc), 64'(last_acc + 1));
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write", wr_address, wr_data);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          check("wr_address", 64'(wr_address), 64'(e[36:32]));
          check("wr_data", 64'(wr_data), 64'(e[31:0]));
        end
      end
      if (done) begin
        done_seen++;
        check("cpu_hold_during_done", 64'(cpu_hold), 64'd1);
        if (done_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done actual=done 1 required=done 0");
        end else begin
          int c;
          c = done_q.pop_front();
          check("word_count_at_done", 64'(word_count), 64'(c));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit l, input int maxwait, output bit acc);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    acc = 1'b0;
    for (int k = 0; k < maxwait && !acc; k++) begin
      @(negedge clk);
      acc = byte_ready;
      tick();
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  // Reference model: bytes pack MSB-first into words, the stream stops at byte_last or after NUM_WORDS words
  task automatic run_session(input logic [7:0] bq[$], input bit use_last, input int gap_max, input bit mid_start);
    int nacc;
    int nwords;
    int d0;
    logic [31:0] words[NUM_WORDS];
    bit acc;
    nacc = 0;
    for (int w = 0; w < NUM_WORDS; w++) words[w] = 32'h0;
    for (int i = 0; i < bq.size(); i++) begin
      if (i / 4 >= NUM_WORDS) break;
      words[i / 4] = words[i / 4] | (32'(bq[i]) << (24 - 8 * (i % 4)));
      nacc++;
      if (use_last && i == bq.size() - 1) break;
    end
    nwords = (nacc + 3) / 4;
    for (int w = 0; w < nwords; w++) exp_q.push_back({5'(w), words[w]});
    done_q.push_back(nwords);
    d0 = done_seen;
    pulse_start();
    for (int i = 0; i < bq.size(); i++) begin
      if (i < nacc) begin
        send_byte(bq[i], use_last && (i == bq.size() - 1), 200, acc);
        if (!acc) check("byte_accept_timeout", 64'(acc), 64'd1);
      end else begin
        send_byte(bq[i], 1'b0, 10, acc);
        check("extra_byte_rejected", 64'(acc), 64'd0);
      end
      if (mid_start && i == bq.size() / 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      repeat ($urandom_range(0, gap_max)) tick();
    end
    for (int k = 0; k < 200 && done_seen == d0; k++) @(posedge clk);
    #1;
    check("done_pulse_count", 64'(done_seen - d0), 64'd1);
    @(negedge clk);
    check("idle_cpu_hold", 64'(cpu_hold), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_word_count", 64'(word_count), 64'(nwords));
    check("writes_outstanding", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    logic [7:0] bq[$];
    bit acc;
    int wr0;

    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_address", 64'(wr_address), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    tick();

    // Two-word program with byte_last on the 8th byte, no gaps then random gaps
    bq = {8'h20, 8'h02, 8'h00, 8'h07, 8'h0C, 8'h00, 8'h00, 8'h03};
    run_session(bq, 1'b1, 0, 1'b0);
    run_session(bq, 1'b1, 4, 1'b0);

    // Short word zero-fill
    bq = {8'h11, 8'h22, 8'h33};
    run_session(bq, 1'b1, 1, 1'b0);

    // Full 128-byte image without byte_last, plus a 129th byte that must be refused
    bq.delete();
    for (int i = 0; i < 129; i++) bq.push_back(8'($urandom));
    run_session(bq, 1'b0, 0, 1'b0);

    // start pulsed mid-session must not disturb anything
    bq.delete();
    for (int i = 0; i < 14; i++) bq.push_back(8'($urandom));
    run_session(bq, 1'b1, 2, 1'b1);

    // Randomized sessions
    for (int s = 0; s < 8; s++) begin
      int n;
      n = $urandom_range(1, 40);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      run_session(bq, 1'b1, 3, 1'b0);
    end

    // Stall in RECV, then reset after 5 accepted bytes
    pulse_start();
    repeat (40) tick();
    @(negedge clk);
    check("stall_byte_ready", 64'(byte_ready), 64'd1);
    check("stall_cpu_hold", 64'(cpu_hold), 64'd1);
    check("stall_word_count", 64'(word_count), 64'd0);
    check("stall_wr_address", 64'(wr_address), 64'd0);
    tick();
    bq = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55};
    exp_q.push_back({5'd0, 32'hDEADBEEF});
    for (int i = 0; i < 5; i++) begin
      send_byte(bq[i], 1'b0, 200, acc);
      if (!acc) check("byte_accept_timeout", 64'(acc), 64'd1);
      repeat ($urandom_range(0, 2)) tick();
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    wr0 = wr_seen;
    @(negedge clk);
    check("abort_byte_ready", 64'(byte_ready), 64'd0);
    check("abort_wr_en", 64'(wr_en), 64'd0);
    check("abort_wr_address", 64'(wr_address), 64'd0);
    check("abort_wr_data", 64'(wr_data), 64'd0);
    check("abort_cpu_hold", 64'(cpu_hold), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_word_count", 64'(word_count), 64'd0);
    repeat (20) tick();
    check("abort_no_writes", 64'(wr_seen - wr0), 64'd0);
    check("abort_pending_writes", 64'(exp_q.size()), 64'd0);

    // New session after the abort starts at address 0
    bq = {8'h11, 8'h22, 8'h33};
    run_session(bq, 1'b1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
